// File: rtl/posit_mult_stage_es3_if.sv
// Operand-pair / product handshake bundle for posit_mult_stage_es3.
// Tag signals exist only when POSIT_MULT_TAG_EN is defined.
interface posit_mult_stage_es3_if #(
   parameter int FBITS = 26,
   parameter int SBITS = 9
`ifdef POSIT_MULT_TAG_EN
   ,parameter int TAG_W = 8
`endif
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 a_sgn;
   logic                 b_sgn;
   logic [SBITS-1:0]     a_scale;
   logic [SBITS-1:0]     b_scale;
   logic [FBITS-1:0]     a_frac;
   logic [FBITS-1:0]     b_frac;
   logic                 a_zero;
   logic                 b_zero;
   logic                 a_inf;
   logic                 b_inf;
   logic                 out_valid;
   logic                 out_ready;
   logic                 out_sgn;
   logic [SBITS:0]       out_scale;
   logic [2*FBITS:0]     out_frac;
   logic                 out_zero;
   logic                 out_inf;
`ifdef POSIT_MULT_TAG_EN
   logic [TAG_W-1:0]     in_tag;
   logic [TAG_W-1:0]     out_tag;
`endif

   // Multiplier side: consumes operands, produces products.
   modport slave (
      input  in_valid, a_sgn, b_sgn, a_scale, b_scale, a_frac, b_frac,
             a_zero, b_zero, a_inf, b_inf, out_ready,
`ifdef POSIT_MULT_TAG_EN
      input  in_tag,
      output out_tag,
`endif
      output in_ready, out_valid, out_sgn, out_scale, out_frac, out_zero, out_inf
   );

   // Environment side: extract stage upstream plus round/pack stage downstream.
   modport master (
      output in_valid, a_sgn, b_sgn, a_scale, b_scale, a_frac, b_frac,
             a_zero, b_zero, a_inf, b_inf, out_ready,
`ifdef POSIT_MULT_TAG_EN
      output in_tag,
      input  out_tag,
`endif
      input  in_ready, out_valid, out_sgn, out_scale, out_frac, out_zero, out_inf
   );
endinterface

// File: rtl/posit_mult_stage_es3.sv
// Three-stage posit<32,3> multiply: sign/scale/mantissa prep, 27x27 product, normalize.
// Optional operand tag pipeline is enabled by defining POSIT_MULT_TAG_EN.
module posit_mult_stage_es3 #(
   parameter int NBITS = 32,
   parameter int ES    = 3,
   parameter int SBITS = 9
`ifdef POSIT_MULT_TAG_EN
   ,parameter int TAG_W = 8
`endif
) (
   input  logic                    clk,
   input  logic                    rst_n,
   posit_mult_stage_es3_if.slave   bus,
   output logic                    busy
);
   localparam int FBITS = NBITS - ES - 3;
   localparam int MW    = FBITS + 1;
   localparam int PW    = 2 * MW;
   localparam int OW    = 2 * FBITS + 1;

   logic              en;

   logic              s1_valid, s1_sgn, s1_zero, s1_inf;
   logic [SBITS:0]    s1_scale;
   logic [MW-1:0]     s1_ma, s1_mb;

   logic              s2_valid, s2_sgn, s2_zero, s2_inf;
   logic [SBITS:0]    s2_scale;
   logic [PW-1:0]     s2_prod;

   logic              s3_valid, s3_sgn, s3_zero, s3_inf;
   logic [SBITS:0]    s3_scale;
   logic [OW-1:0]     s3_frac;

   logic              n_sgn;
   logic [SBITS:0]    n_scale;
   logic [OW-1:0]     n_frac;
   logic              in_inf;

`ifdef POSIT_MULT_TAG_EN
   logic [TAG_W-1:0]  s1_tag, s2_tag, s3_tag;
`endif

   // One enable for the whole pipe: a stalled output freezes every stage, bubbles included.
   assign en          = ~s3_valid | bus.out_ready;
   assign bus.in_ready = en;
   assign busy        = s1_valid | s2_valid | s3_valid;
   assign in_inf      = bus.a_inf | bus.b_inf;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      n_sgn   = s2_sgn;
      n_scale = s2_scale;
      n_frac  = '0;
      if (s2_prod[PW-1]) begin
         n_scale = s2_scale + (SBITS+1)'(1);
         n_frac  = s2_prod[PW-2:0];
      end else begin
         n_frac  = {s2_prod[PW-3:0], 1'b0};
      end
      if (s2_inf | s2_zero) begin
         n_sgn   = 1'b0;
         n_scale = '0;
         n_frac  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: data registers are reset along with the valid bits so every out_* reads 0 after reset.
         s1_valid <= 1'b0;
         s1_sgn   <= 1'b0;
         s1_scale <= '0;
         s1_ma    <= '0;
         s1_mb    <= '0;
         s1_zero  <= 1'b0;
         s1_inf   <= 1'b0;
         s2_valid <= 1'b0;
         s2_sgn   <= 1'b0;
         s2_scale <= '0;
         s2_prod  <= '0;
         s2_zero  <= 1'b0;
         s2_inf   <= 1'b0;
         s3_valid <= 1'b0;
         s3_sgn   <= 1'b0;
         s3_scale <= '0;
         s3_frac  <= '0;
         s3_zero  <= 1'b0;
         s3_inf   <= 1'b0;
`ifdef POSIT_MULT_TAG_EN
         s1_tag   <= '0;
         s2_tag   <= '0;
         s3_tag   <= '0;
`endif
      end else if (en) begin
         // NOTE: non-blocking assignments let every stage read the previous cycle's value of its upstream.
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_sgn   <= bus.a_sgn ^ bus.b_sgn;
            s1_scale <= {bus.a_scale[SBITS-1], bus.a_scale} + {bus.b_scale[SBITS-1], bus.b_scale};
            s1_ma    <= {1'b1, bus.a_frac};
            s1_mb    <= {1'b1, bus.b_frac};
            s1_inf   <= in_inf;
            s1_zero  <= (bus.a_zero | bus.b_zero) & ~in_inf;
`ifdef POSIT_MULT_TAG_EN
            s1_tag   <= bus.in_tag;
`endif
         end

         s2_valid <= s1_valid;
         s2_sgn   <= s1_sgn;
         s2_scale <= s1_scale;
         s2_prod  <= PW'(s1_ma) * PW'(s1_mb);
         s2_zero  <= s1_zero;
         s2_inf   <= s1_inf;

         s3_valid <= s2_valid;
         s3_sgn   <= n_sgn;
         s3_scale <= n_scale;
         s3_frac  <= n_frac;
         s3_zero  <= s2_zero;
         s3_inf   <= s2_inf;
`ifdef POSIT_MULT_TAG_EN
         s2_tag   <= s1_tag;
         s3_tag   <= s2_tag;
`endif
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.out_sgn   = s3_sgn;
   assign bus.out_scale = s3_scale;
   assign bus.out_frac  = s3_frac;
   assign bus.out_zero  = s3_zero;
   assign bus.out_inf   = s3_inf;
`ifdef POSIT_MULT_TAG_EN
   assign bus.out_tag   = s3_tag;
`endif
endmodule
